// File: rtl/dmi_arb_pkg.sv
// Shared types and status codes for the two-requester DMI port arbiter.
package dmi_arb_pkg;

    localparam int DMI_AWIDTH = 7;

    localparam logic [1:0] DMI_OK   = 2'b00;
    localparam logic [1:0] DMI_FAIL = 2'b10;
    localparam logic [1:0] DMI_BUSY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [DMI_AWIDTH-1:0] addr;
        logic [31:0]           wdata;
    } dmi_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    assign grant0 = valid0 & (~valid1 | last_grant);
    assign grant1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/dmi_req_arbiter.sv
// Arbitrates the single DMI register port between the JTAG DTM path and a
// secondary debug master, one transaction at a time with a response timeout.
module dmi_req_arbiter
    import dmi_arb_pkg::*;
#(
    parameter  int AWIDTH  = DMI_AWIDTH,
    parameter  int TIMEOUT = 255,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [31:0]       rsp0_rdata,
    output logic [1:0]        rsp0_status,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [31:0]       rsp1_rdata,
    output logic [1:0]        rsp1_status,
    input  logic              errclr0,
    input  logic              errclr1,
    output logic              sticky_err0,
    output logic              sticky_err1,
    output logic              dmi_reg_en,
    output logic              dmi_reg_wr_en,
    output logic [AWIDTH-1:0] dmi_reg_addr,
    output logic [31:0]       dmi_reg_wdata,
    input  logic              dmi_rsp_valid,
    input  logic [31:0]       dmi_reg_rdata
);

    arb_state_e       state_r;
    logic             last_grant_r;
    logic             owner_r;
    dmi_req_t         req_r;
    dmi_req_t         req_sel_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       sticky_r;
    logic [1:0]       sticky_set_s;
    logic [1:0]       rsp_valid_r;
    logic [31:0]      rdata_r;
    logic [1:0]       status_r;
    logic             dmi_en_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic             timeout_s;
    logic             rsp_ready_s;

    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant0     (grant0_s),
        .grant1     (grant1_s)
    );

    assign req0_ready  = (state_r == ST_IDLE) & grant0_s;
    assign req1_ready  = (state_r == ST_IDLE) & grant1_s;
    assign accept_s    = req0_ready | req1_ready;
    assign rsp_ready_s = owner_r ? rsp1_ready : rsp0_ready;
    assign timeout_s   = (state_r == ST_WAIT) & ~dmi_rsp_valid
                         & (cnt_r == CNT_W'(TIMEOUT - 1));

    // Select the granted requester's fields for latching on accept.
    always_comb begin
        req_sel_s = '0;
        if (grant1_s) begin
            req_sel_s.wr    = req1_wr;
            req_sel_s.addr  = DMI_AWIDTH'(req1_addr);
            req_sel_s.wdata = req1_wdata;
        end else begin
            req_sel_s.wr    = req0_wr;
            req_sel_s.addr  = DMI_AWIDTH'(req0_addr);
            req_sel_s.wdata = req0_wdata;
        end
    end

    // Sticky error set request for the owner of a timed-out access.
    always_comb begin
        sticky_set_s = 2'b00;
        if (timeout_s) begin
            sticky_set_s = owner_r ? 2'b10 : 2'b01;
        end else begin
            sticky_set_s = 2'b00;
        end
    end

    // Sticky error flags; a timeout set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sticky_r <= 2'b00;
        end else begin
            sticky_r <= (sticky_r & ~{errclr1, errclr0}) | sticky_set_s;
        end
    end

    // Transaction sequencer: accept, issue, wait with timeout, respond.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            req_r        <= '0;
            cnt_r        <= '0;
            rsp_valid_r  <= 2'b00;
            rdata_r      <= 32'h0;
            status_r     <= DMI_OK;
            dmi_en_r     <= 1'b0;
        end else begin
            dmi_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r      <= grant1_s;
                        last_grant_r <= grant1_s;
                        // A requester with a pending error is refused without touching the DMI.
                        if (sticky_r[grant1_s]) begin
                            rsp_valid_r[grant1_s] <= 1'b1;
                            status_r              <= DMI_BUSY;
                            rdata_r               <= 32'h0;
                            state_r               <= ST_RESP;
                        end else begin
                            req_r    <= req_sel_s;
                            dmi_en_r <= 1'b1;
                            state_r  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dmi_rsp_valid) begin
                        rdata_r              <= req_r.wr ? 32'h0 : dmi_reg_rdata;
                        status_r             <= DMI_OK;
                        rsp_valid_r[owner_r] <= 1'b1;
                        state_r              <= ST_RESP;
                    end else if (timeout_s) begin
                        rdata_r              <= 32'h0;
                        status_r             <= DMI_FAIL;
                        rsp_valid_r[owner_r] <= 1'b1;
                        state_r              <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_s) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid    = rsp_valid_r[0];
    assign rsp1_valid    = rsp_valid_r[1];
    assign rsp0_rdata    = rdata_r;
    assign rsp1_rdata    = rdata_r;
    assign rsp0_status   = status_r;
    assign rsp1_status   = status_r;
    assign sticky_err0   = sticky_r[0];
    assign sticky_err1   = sticky_r[1];
    assign dmi_reg_en    = dmi_en_r;
    assign dmi_reg_wr_en = dmi_en_r & req_r.wr;
    assign dmi_reg_addr  = AWIDTH'(req_r.addr);
    assign dmi_reg_wdata = req_r.wdata;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Randomized bench for dmi_req_arbiter against a transaction-level timing model.
module tb_dmi_req_arbiter;
    import dmi_arb_pkg::*;

    localparam int AW = 7;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic          req0_wr = 1'b0, req1_wr = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [31:0]   req0_wdata = '0, req1_wdata = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0]   rsp0_rdata, rsp1_rdata;
    logic [1:0]    rsp0_status, rsp1_status;
    logic          errclr0 = 1'b0, errclr1 = 1'b0;
    logic          sticky_err0, sticky_err1;
    logic          dmi_reg_en, dmi_reg_wr_en;
    logic [AW-1:0] dmi_reg_addr;
    logic [31:0]   dmi_reg_wdata;
    logic          dmi_rsp_valid = 1'b0;
    logic [31:0]   dmi_reg_rdata = '0;

    always #5 clk = ~clk;

    dmi_req_arbiter #(.AWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_l(rst_l),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .rsp0_status(rsp0_status),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .rsp1_status(rsp1_status),
        .errclr0(errclr0), .errclr1(errclr1),
        .sticky_err0(sticky_err0), .sticky_err1(sticky_err1),
        .dmi_reg_en(dmi_reg_en), .dmi_reg_wr_en(dmi_reg_wr_en),
        .dmi_reg_addr(dmi_reg_addr), .dmi_reg_wdata(dmi_reg_wdata),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_reg_rdata(dmi_reg_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one transaction in flight, described by the cycle
    // numbers at which its strobe and its response must appear.
    int          cyc = 0;
    bit          busy = 0;
    int          owner = 0;
    bit          m_last = 1;
    bit          m_sticky [2];
    bit          cur_sticky, cur_wr;
    int          en_at = -10, rsp_at = 0, cur_d = 0, hold_left = 0;
    logic [31:0] cur_rdv;
    logic [AW-1:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    bit          p_valid [2];
    bit          p_wr [2];
    logic [AW-1:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] p_rdv [2];
    int          p_d [2];
    int          p_hold [2];
    int          p_refill [2];
    bit          clr_pulse [2];
    bit          rand_clr = 0;
    int          grant_log [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int n, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] wd, input int d, input int h,
                           input logic [31:0] rdv);
        p_valid[n] = 1'b1; p_wr[n] = wr; p_addr[n] = a; p_wdata[n] = wd;
        p_d[n] = d; p_hold[n] = h; p_rdv[n] = rdv;
    endtask

    task automatic rand_req(input int n);
        set_req(n, 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                $urandom_range(0, TO + 2), $urandom_range(0, 3), $urandom);
    endtask

    task automatic cycle();
        bit   rdy_own, acc, acc_sticky, done;
        int   g;
        logic [1:0] clr;
        @(negedge clk);
        cyc++;
        req0_valid = p_valid[0]; req0_wr = p_wr[0]; req0_addr = p_addr[0]; req0_wdata = p_wdata[0];
        req1_valid = p_valid[1]; req1_wr = p_wr[1]; req1_addr = p_addr[1]; req1_wdata = p_wdata[1];
        rdy_own = busy && cyc >= rsp_at && hold_left == 0;
        if (busy && cyc >= rsp_at && hold_left > 0) hold_left--;
        rsp0_ready = (busy && owner == 0) ? rdy_own : 1'($urandom_range(0, 1));
        rsp1_ready = (busy && owner == 1) ? rdy_own : 1'($urandom_range(0, 1));
        if (busy && !cur_sticky && cyc > en_at && cyc < rsp_at) begin
            dmi_rsp_valid = (cyc == en_at + 1 + cur_d);
            dmi_reg_rdata = dmi_rsp_valid ? cur_rdv : $urandom;
        end else begin
            dmi_rsp_valid = ($urandom_range(0, 3) == 0);
            dmi_reg_rdata = $urandom;
        end
        clr[0] = clr_pulse[0] | (rand_clr && $urandom_range(0, 15) == 0);
        clr[1] = clr_pulse[1] | (rand_clr && $urandom_range(0, 15) == 0);
        errclr0 = clr[0]; errclr1 = clr[1];
        clr_pulse[0] = 0; clr_pulse[1] = 0;

        acc = !busy && (p_valid[0] || p_valid[1]);
        g   = (p_valid[0] && p_valid[1]) ? int'(!m_last) : int'(p_valid[1]);
        #1;
        check_eq("req0_ready", req0_ready, acc && g == 0);
        check_eq("req1_ready", req1_ready, acc && g == 1);
        check_eq("dmi_reg_en", dmi_reg_en, busy && !cur_sticky && cyc == en_at);
        check_eq("dmi_reg_wr_en", dmi_reg_wr_en, busy && !cur_sticky && cyc == en_at && cur_wr);
        check_eq("dmi_reg_addr", dmi_reg_addr, m_addr);
        check_eq("dmi_reg_wdata", dmi_reg_wdata, m_wdata);
        check_eq("rsp0_valid", rsp0_valid, busy && owner == 0 && cyc >= rsp_at);
        check_eq("rsp1_valid", rsp1_valid, busy && owner == 1 && cyc >= rsp_at);
        if (busy && cyc >= rsp_at) begin
            check_eq("rsp_status", owner ? rsp1_status : rsp0_status,
                     cur_sticky ? DMI_BUSY : (cur_d < TO ? DMI_OK : DMI_FAIL));
            check_eq("rsp_rdata", owner ? rsp1_rdata : rsp0_rdata,
                     (cur_sticky || cur_wr || cur_d >= TO) ? 32'h0 : cur_rdv);
        end
        check_eq("sticky_err0", sticky_err0, m_sticky[0]);
        check_eq("sticky_err1", sticky_err1, m_sticky[1]);
        if (req0_valid && req0_ready) grant_log.push_back(0);
        if (req1_valid && req1_ready) grant_log.push_back(1);

        // Advance the model across the coming rising edge.
        acc_sticky = acc ? m_sticky[g] : 1'b0;
        done = rdy_own;
        for (int n = 0; n < 2; n++) if (clr[n]) m_sticky[n] = 0;
        if (busy && !cur_sticky && cur_d >= TO && cyc == rsp_at - 1) m_sticky[owner] = 1;
        if (done) busy = 0;
        if (acc) begin
            busy = 1; owner = g; m_last = 1'(g); cur_sticky = acc_sticky;
            cur_wr = p_wr[g]; cur_d = p_d[g]; hold_left = p_hold[g]; cur_rdv = p_rdv[g];
            if (acc_sticky) begin
                en_at = -10; rsp_at = cyc + 1;
            end else begin
                en_at  = cyc + 1;
                rsp_at = cyc + 3 + ((cur_d < TO) ? cur_d : TO - 1);
                m_addr = p_addr[g]; m_wdata = p_wdata[g];
            end
            if (p_refill[g] > 0) begin
                p_refill[g]--;
                rand_req(g);
            end else begin
                p_valid[g] = 0;
            end
        end
    endtask

    task automatic run();
        int b = 0;
        do begin
            cycle();
            b++;
        end while ((busy || p_valid[0] || p_valid[1]) && b < 300);
        check_eq("run_budget", 32'(b < 300), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; dmi_rsp_valid = 0; errclr0 = 0; errclr1 = 0;
        rst_l = 1'b0;
        #1;
        check_eq("rst_req0_ready", req0_ready, 0);
        check_eq("rst_req1_ready", req1_ready, 0);
        check_eq("rst_rsp0_valid", rsp0_valid, 0);
        check_eq("rst_rsp1_valid", rsp1_valid, 0);
        check_eq("rst_rsp0_rdata", rsp0_rdata, 0);
        check_eq("rst_rsp1_status", rsp1_status, 0);
        check_eq("rst_dmi_en", dmi_reg_en, 0);
        check_eq("rst_dmi_wr_en", dmi_reg_wr_en, 0);
        check_eq("rst_dmi_addr", dmi_reg_addr, 0);
        check_eq("rst_dmi_wdata", dmi_reg_wdata, 0);
        check_eq("rst_sticky0", sticky_err0, 0);
        check_eq("rst_sticky1", sticky_err1, 0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        busy = 0; m_last = 1; m_sticky[0] = 0; m_sticky[1] = 0;
        m_addr = '0; m_wdata = '0; en_at = -10;
        for (int n = 0; n < 2; n++) begin
            p_valid[n] = 0; p_refill[n] = 0; clr_pulse[n] = 0;
        end
    endtask

    initial begin
        do_reset();
        // Read on requester 0, response three cycles after the strobe.
        set_req(0, 1'b0, 7'h11, 32'h0, 2, 0, 32'hDEADBEEF);
        run();
        // Write on requester 1.
        set_req(1, 1'b1, 7'h10, 32'h1, 0, 0, 32'hCAFE0000);
        run();
        // Contention: both valid continuously for four transactions.
        grant_log.delete();
        p_refill[0] = 1; p_refill[1] = 1;
        rand_req(0); rand_req(1);
        run();
        check_eq("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_eq("grant_order", grant_log[i], i % 2);
        // Timeout, sticky refusal, then clear and a normal access.
        set_req(0, 1'b0, 7'h20, 32'h0, TO + 5, 0, 32'h12345678);
        run();
        set_req(0, 1'b0, 7'h21, 32'h0, 1, 0, 32'h55AA55AA);
        run();
        clr_pulse[0] = 1;
        cycle();
        set_req(0, 1'b0, 7'h22, 32'h0, 1, 0, 32'hA5A5A5A5);
        run();
        // Backpressure on requester 1 while requester 0 waits.
        set_req(1, 1'b0, 7'h33, 32'h0, 0, 5, 32'h0BADF00D);
        set_req(0, 1'b1, 7'h34, 32'h77, 0, 0, 32'h0);
        run();
        // Response on the last wait cycle, then a real timeout on requester 1.
        set_req(1, 1'b0, 7'h40, 32'h0, TO - 1, 0, 32'h13579BDF);
        run();
        set_req(1, 1'b0, 7'h41, 32'h0, TO, 0, 32'h2468ACE0);
        run();
        clr_pulse[1] = 1;
        cycle();
        // Idle with stray response pulses.
        repeat (10) cycle();
        // Reset during WAIT, then a normal request.
        set_req(0, 1'b1, 7'h50, 32'hFEEDFACE, 50, 0, 32'h0);
        repeat (4) cycle();
        do_reset();
        set_req(1, 1'b0, 7'h51, 32'h0, 0, 0, 32'h89ABCDEF);
        run();
        // Random traffic with random error clears.
        rand_clr = 1;
        for (int i = 0; i < 120; i++) begin
            for (int n = 0; n < 2; n++)
                if (!p_valid[n] && $urandom_range(0, 2) == 0) rand_req(n);
            cycle();
        end
        rand_clr = 0;
        run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
- Shares the single debug-module DMI register port between two requesters:
  - Requester 0: the JTAG DTM path, i.e. TAP `wr_en`/`rd_en`/`wr_addr`/`wr_data` after clock-domain crossing.
  - Requester 1: a secondary debug master, e.g. the test/boot-ROM debug agent.
- Grants one outstanding transaction at a time, round-robin.
- Sequences the DMI access and enforces a response timeout.
- Returns read data plus a 2-bit DMI status per requester, and keeps a sticky error per requester.

Parameters:
- AWIDTH, 7, DMI address width (same meaning as the TAP's AWIDTH).
- TIMEOUT, 255, max WAIT cycles before a failed response; legal range 2..2^16-1.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk, in, 1, core clock.
- rst_l, in, 1, asynchronous active-low reset.
- reqN_valid, in, 1, request valid, N=0,1.
- reqN_ready, out, 1, request accepted this cycle.
- reqN_wr, in, 1, 1=write, 0=read.
- reqN_addr, in, AWIDTH, DMI register address.
- reqN_wdata, in, 32, write data.
- rspN_valid, out, 1, response valid.
- rspN_ready, in, 1, response consumed.
- rspN_rdata, out, 32, read data (0 for writes/errors).
- rspN_status, out, 2, 00 ok, 10 failed, 11 busy/sticky.
- errclrN, in, 1, pulse: clear sticky error N (driven from TAP `dmi_reset`/`dmi_hard_reset` for N=0).
- sticky_errN, out, 1, sticky error flag.
- dmi_reg_en, out, 1, DMI access strobe (1 cycle).
- dmi_reg_wr_en, out, 1, DMI write qualifier.
- dmi_reg_addr, out, AWIDTH, DMI address.
- dmi_reg_wdata, out, 32, DMI write data.
- dmi_rsp_valid, in, 1, DMI access complete.
- dmi_reg_rdata, in, 32, DMI read data, valid with dmi_rsp_valid.

Behaviour:
- Reset (async, rst_l=0):
  - state=IDLE; all ready/valid/en outputs 0; rdata/status/addr/wdata 0.
  - sticky_err0/1=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) & grantN.
  - Only one requester valid → it is granted.
  - Both valid → the requester ≠ last_grant is granted.
  - On accept, latch owner, wr, addr, wdata, and update last_grant.
  - If sticky_err[owner]=1: go to RESP with status 11 and rdata 0; no DMI access.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - dmi_reg_en=1; dmi_reg_wr_en=latched wr; addr/wdata driven from latches.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - dmi_rsp_valid=1 → capture rdata (reads) or 0 (writes), status 00, go to RESP.
  - Otherwise increment the counter.
  - Counter==TIMEOUT-1 and no rsp → status 10, rdata 0, set sticky_err[owner], go to RESP.
  - dmi_rsp_valid arriving in the same cycle as the timeout compare takes priority (status 00).
- RESP:
  - rsp[owner]_valid=1; rdata/status held stable until rsp[owner]_ready=1; then go to IDLE.
  - The other requester's rsp_valid stays 0.
- dmi_rsp_valid is ignored outside WAIT (stray pulses have no effect).
- dmi_reg_addr/wdata hold their last value outside ISSUE; dmi_reg_en and dmi_reg_wr_en are 0 outside ISSUE.
- Latency, normal path: accept at edge t0 → dmi_reg_en during t0+1 → rsp at earliest t0+2 → rspN_valid from t0+3.
- Latency, sticky path: rspN_valid from t0+1.
- errclrN:
  - Clears sticky_errN next edge.
  - Same-cycle set (timeout) and clear on the same requester: set wins.
  - errclr has no effect on an in-flight transaction.
- Requests are never dropped: reqN_valid may stay high until ready; inputs are sampled only on accept.
- Reset mid-operation: returns immediately to the reset state; no response is issued for the in-flight request.

Decomposition:
- Package dmi_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP).
  - DMI status localparams: DMI_OK=2'b00, DMI_FAIL=2'b10, DMI_BUSY=2'b11.
  - Request struct {wr, addr, wdata}.
- Sub-module rr_arb2: 2-way round-robin grant from {valid0, valid1, last_grant}, purely combinational.
- FSM, timeout counter, and sticky flags stay in the top module.

Test Plan:
- Read, req0: addr 7'h11; dmi_rsp_valid 3 cycles after en with rdata 32'hDEADBEEF → rsp0_valid, rdata DEADBEEF, status 00; dmi_reg_en high exactly 1 cycle, wr_en 0.
- Write, req1: addr 7'h10, wdata 32'h1 → dmi_reg_en with wr_en=1, addr 10, wdata 1; response rdata 0, status 00; req0 untouched.
- Contention: both valid continuously after reset for 4 transactions → grants 0,1,0,1; each rsp routed only to its owner.
- Timeout: TIMEOUT=8, no dmi_rsp_valid → rsp0 status 10 after 8 WAIT cycles; sticky_err0=1; next req0 gets status 11 at t0+1 with no dmi_reg_en; errclr0 pulse → next req0 is a normal access.
- Backpressure/corners: hold rsp1_ready=0 for 5 cycles → rsp1 data/status stable, req0 not accepted meanwhile. Stray dmi_rsp_valid in IDLE is ignored. rsp arriving on the timeout cycle gives status 00. rst_l low during WAIT → all outputs 0, next request proceeds normally.
